psx_poll_scheduler: RTL and testbench

Transaction sequencer that periodically polls a PSX controller through the byte-exchange engine (bit-level psx_clk/cmd/data shifter). Owns ATT, issues the 5-byte digital poll (0x01, 0x42, 0x00, 0x00, 0x00) one byte at a time, paces each byte on the controller's ACK with a timeout, validates the response, and publishes latched button state. Sits between the bit-level serial engine and the game logic.

---
 rtl/psx_poll_scheduler.sv | 179 +++++++++++++++++
 tb/tb_psx_poll_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_poll_scheduler.sv
// PSX controller poll sequencer: owns ATT, issues the 5-byte digital poll one byte at a time
// through the byte-exchange engine, paces bytes on ACK and publishes validated button state.
module psx_poll_scheduler #(
  parameter int POLL_INTERVAL = 117,
  parameter int ACK_TIMEOUT   = 8,
  parameter int ATT_SETUP     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_ack,
  input  logic        i_byte_done,
  input  logic [7:0]  i_byte_rx,
  output logic        o_att,
  output logic        o_byte_start,
  output logic [7:0]  o_byte_tx,
  output logic [15:0] o_buttons,
  output logic        o_buttons_valid,
  output logic [7:0]  o_ctrl_id,
  output logic        o_err,
  output logic [2:0]  o_state
);

  localparam int IW = $clog2(POLL_INTERVAL + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int SW = $clog2(ATT_SETUP + 1);
  localparam logic [IW-1:0] INTERVAL_RELOAD = IW'(POLL_INTERVAL - 1);
  localparam logic [TW-1:0] TMO_LAST        = TW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] SETUP_LAST      = SW'(ATT_SETUP);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_FINISH    = 3'd5,
    S_ABORT     = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_ack_s1;
  logic            r_ack_s2;
  logic            r_ack_d;
  logic            r_ack_seen;
  logic            w_ack_fall;
  logic [IW-1:0]   r_interval;
  logic [SW-1:0]   r_setup_cnt;
  logic [TW-1:0]   r_tmo;
  logic [2:0]      r_idx;
  logic [7:0]      r_id_shadow;
  logic [7:0]      r_btn_lo;
  logic [15:0]     r_buttons;
  logic [7:0]      r_ctrl_id;

  // ACK is an asynchronous active-low pulse; only its synchronized falling edge counts.
  assign w_ack_fall = r_ack_d & ~r_ack_s2;

  always_comb begin
    w_state_next    = r_state;
    o_att           = 1'b1;
    o_byte_start    = 1'b0;
    o_buttons_valid = 1'b0;
    o_err           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_interval == '0 && i_enable) w_state_next = S_SETUP;
      end
      S_SETUP: begin
        o_att = 1'b0;
        if (r_setup_cnt == SETUP_LAST) w_state_next = S_SEND;
      end
      S_SEND: begin
        o_att        = 1'b0;
        o_byte_start = 1'b1;
        w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        o_att = 1'b0;
        if (i_byte_done) begin
          if (r_idx == 3'd2 && i_byte_rx != 8'h5A) w_state_next = S_ABORT;
          else if (r_idx == 3'd4)                 w_state_next = S_FINISH;
          else                                    w_state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        o_att = 1'b0;
        if (r_ack_seen)             w_state_next = S_SEND;
        else if (r_tmo == TMO_LAST) w_state_next = S_ABORT;
      end
      S_FINISH: begin
        o_buttons_valid = 1'b1;
        w_state_next    = S_IDLE;
      end
      S_ABORT: begin
        o_err        = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_idx)
      3'd0:    o_byte_tx = 8'h01;
      3'd1:    o_byte_tx = 8'h42;
      default: o_byte_tx = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ack_s1    <= 1'b1;
      r_ack_s2    <= 1'b1;
      r_ack_d     <= 1'b1;
      r_ack_seen  <= 1'b0;
      r_interval  <= '0;
      r_setup_cnt <= '0;
      r_tmo       <= '0;
      r_idx       <= 3'd0;
      r_id_shadow <= 8'hFF;
      r_btn_lo    <= 8'hFF;
      r_buttons   <= 16'hFFFF;
      r_ctrl_id   <= 8'hFF;
    end else begin
      r_ack_s1 <= i_ack;
      r_ack_s2 <= r_ack_s1;
      r_ack_d  <= r_ack_s2;
      if (r_state == S_SEND)  r_ack_seen <= 1'b0;
      else if (w_ack_fall)    r_ack_seen <= 1'b1;

      // Counter runs through the whole ATT-high gap, so FINISH/ABORT cycles count too.
      if (r_interval != '0) r_interval <= r_interval - 1'b1;

      case (r_state)
        S_IDLE: begin
          r_idx       <= 3'd0;
          r_setup_cnt <= '0;
        end
        S_SETUP: r_setup_cnt <= r_setup_cnt + 1'b1;
        S_WAIT_DONE: begin
          r_tmo <= '0;
          if (i_byte_done) begin
            case (r_idx)
              3'd1: r_id_shadow <= i_byte_rx;
              3'd3: r_btn_lo    <= i_byte_rx;
              3'd4: begin
                r_buttons <= {i_byte_rx, r_btn_lo};
                r_ctrl_id <= r_id_shadow;
              end
              default: ;
            endcase
          end
        end
        S_WAIT_ACK: begin
          if (r_ack_seen) r_idx <= r_idx + 3'd1;
          else            r_tmo <= r_tmo + 1'b1;
        end
        default: ;
      endcase

      if (w_state_next == S_FINISH || w_state_next == S_ABORT) r_interval <= INTERVAL_RELOAD;
    end
  end

  assign o_buttons = r_buttons;
  assign o_ctrl_id = r_ctrl_id;
  assign o_state   = r_state;

endmodule

// File: tb/tb_psx_poll_scheduler.sv
// Bench for psx_poll_scheduler: emulates the byte engine and controller ACK, and checks each poll
// against outcomes predicted from the protocol rules (byte sequence, abort causes, timing, latching).
module tb_psx_poll_scheduler;

  localparam int POLL_INTERVAL = 117;
  localparam int ACK_TIMEOUT   = 8;
  localparam int ATT_SETUP     = 2;
  localparam int SYNC_LAT      = 3;
  localparam int NO_ACK        = 99;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        ack;
  logic        byte_done;
  logic [7:0]  byte_rx;
  logic        att;
  logic        byte_start;
  logic [7:0]  byte_tx;
  logic [15:0] buttons;
  logic        buttons_valid;
  logic [7:0]  ctrl_id;
  logic        err;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  psx_poll_scheduler #(
    .POLL_INTERVAL(POLL_INTERVAL),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .ATT_SETUP    (ATT_SETUP)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_ack          (ack),
    .i_byte_done    (byte_done),
    .i_byte_rx      (byte_rx),
    .o_att          (att),
    .o_byte_start   (byte_start),
    .o_byte_tx      (byte_tx),
    .o_buttons      (buttons),
    .o_buttons_valid(buttons_valid),
    .o_ctrl_id      (ctrl_id),
    .o_err          (err),
    .o_state        (dbg_state)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          g_cyc   = 0;
  int          e_fall  = -1;
  logic [7:0]  exp_q[$];
  logic [15:0] m_buttons = 16'hFFFF;
  logic [7:0]  m_id      = 8'hFF;

  logic [7:0]  p_rx[5];
  int          p_lat[5];
  int          p_ackd[4];
  int          p_rst_byte;
  bit          p_drop_en;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, obs, exp, g_cyc);
    end
  endtask

  function automatic logic [7:0] poll_cmd(input int i);
    case (i)
      0:       return 8'h01;
      1:       return 8'h42;
      default: return 8'h00;
    endcase
  endfunction

  // Sample and drive #1 after each rising edge; the cycle number names the state after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    g_cyc++;
  endtask

  task automatic check_reset_vals(input string where);
    check_eq({where, "_att"},     32'(att), 1);
    check_eq({where, "_start"},   32'(byte_start), 0);
    check_eq({where, "_tx"},      32'(byte_tx), 32'h01);
    check_eq({where, "_buttons"}, 32'(buttons), 32'hFFFF);
    check_eq({where, "_valid"},   32'(buttons_valid), 0);
    check_eq({where, "_id"},      32'(ctrl_id), 32'hFF);
    check_eq({where, "_err"},     32'(err), 0);
  endtask

  task automatic set_poll(input logic [39:0] rx_bytes, input int lat, input int d);
    for (int k = 0; k < 5; k++) begin
      p_rx[k]  = rx_bytes[39-8*k -: 8];
      p_lat[k] = lat;
    end
    for (int k = 0; k < 4; k++) p_ackd[k] = d;
    p_rst_byte = -1;
    p_drop_en  = 1'b0;
  endtask

  task automatic run_poll();
    int bi, nst, d_cyc, a_cyc, rst_cyc, fall_cyc, end_cyc, nb, exp_end, kt;
    int dh[5];
    bit ok, sig_bad, prev_att, got_err, got_valid, did_rst;
    logic [15:0] obs_btn;
    logic [7:0]  obs_id;
    bi = 0; nst = 0; d_cyc = -1; a_cyc = -100; rst_cyc = -100;
    fall_cyc = -1; end_cyc = -1; kt = 0;
    prev_att = 1'b1; got_err = 1'b0; got_valid = 1'b0; did_rst = 1'b0;
    obs_btn = 16'h0; obs_id = 8'h0;
    for (int k = 0; k < 5; k++) dh[k] = -1000;

    // Reference outcome: walk the bytes, stop on a bad signature or an ACK that lands too late.
    nb = 0; ok = 1'b1; sig_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      nb = k + 1;
      if (k == 2 && p_rx[2] != 8'h5A) begin ok = 1'b0; sig_bad = 1'b1; break; end
      if (k == 4) break;
      if (p_ackd[k] == NO_ACK || p_ackd[k] + SYNC_LAT > ACK_TIMEOUT) begin
        ok = 1'b0; kt = k; break;
      end
    end
    exp_q.delete();
    for (int k = 0; k < nb; k++) exp_q.push_back(poll_cmd(k));

    for (int c = 0; c < 400; c++) begin
      tick();
      byte_done = 1'b0;
      byte_rx   = 8'($urandom);
      if (g_cyc == a_cyc)     ack = 1'b0;
      if (g_cyc == a_cyc + 2) ack = 1'b1;
      if (g_cyc == rst_cyc + 1) begin
        check_reset_vals("midrst");
        rst_n   = 1'b1;
        e_fall  = g_cyc + 1;
        did_rst = 1'b1;
        break;
      end
      if (g_cyc == rst_cyc) rst_n = 1'b0;
      if (prev_att && !att) begin
        fall_cyc = g_cyc;
        if (e_fall >= 0) check_eq("att_fall_cycle", 32'(g_cyc), 32'(e_fall));
      end
      prev_att = att;
      if (byte_start) begin
        nst++;
        if (exp_q.size() == 0) check_eq("extra_byte_start", 32'(nst), 32'(nb));
        else check_eq("byte_tx", 32'(byte_tx), 32'(exp_q.pop_front()));
        if (nst == 1) check_eq("att_setup_len", 32'(g_cyc - fall_cyc), 32'(ATT_SETUP + 1));
        if (bi < 5) begin
          d_cyc = g_cyc + p_lat[bi];
          a_cyc = (bi < 4 && p_ackd[bi] != NO_ACK) ? d_cyc + p_ackd[bi] : -100;
        end
        if (p_drop_en && bi == 1) enable = 1'b0;
      end
      if (g_cyc == d_cyc && bi < 5) begin
        byte_done = 1'b1;
        byte_rx   = p_rx[bi];
        check_eq("tx_stable", 32'(byte_tx), 32'(poll_cmd(bi)));
        dh[bi] = g_cyc;
        if (p_rst_byte == bi) rst_cyc = g_cyc + 2;
        bi++;
      end
      if (err || buttons_valid) begin
        end_cyc   = g_cyc;
        got_err   = err;
        got_valid = buttons_valid;
        obs_btn   = buttons;
        obs_id    = ctrl_id;
        check_eq("att_high_at_end", 32'(att), 1);
        break;
      end
    end
    ack = 1'b1;
    byte_done = 1'b0;
    if (did_rst) begin
      m_buttons = 16'hFFFF;
      m_id      = 8'hFF;
      return;
    end

    tick();
    check_eq("pulse_one_cycle", 32'({buttons_valid, err}), 0);
    check_eq("att_idle", 32'(att), 1);
    check_eq("n_byte_starts", 32'(nst), 32'(nb));
    if (ok)           exp_end = dh[4] + 1;
    else if (sig_bad) exp_end = dh[2] + 1;
    else              exp_end = dh[kt] + 1 + ACK_TIMEOUT;
    check_eq("end_cycle", 32'(end_cyc), 32'(exp_end));
    check_eq("err_pulse", 32'(got_err), 32'(!ok));
    check_eq("valid_pulse", 32'(got_valid), 32'(ok));
    if (ok) begin
      m_buttons = {p_rx[4], p_rx[3]};
      m_id      = p_rx[1];
    end
    check_eq("buttons", 32'(obs_btn), 32'(m_buttons));
    check_eq("ctrl_id", 32'(obs_id), 32'(m_id));
    e_fall = p_drop_en ? -1 : end_cyc + POLL_INTERVAL;
  endtask

  task automatic idle_no_poll(input int n, input string tag);
    int att_low, starts;
    att_low = 0; starts = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      byte_done = ($urandom_range(0, 15) == 0);
      byte_rx   = 8'($urandom);
      if (!att) att_low++;
      if (byte_start) starts++;
    end
    byte_done = 1'b0;
    tick();
    check_eq({tag, "_att_low"}, 32'(att_low), 0);
    check_eq({tag, "_starts"}, 32'(starts), 0);
    check_eq({tag, "_buttons"}, 32'(buttons), 32'(m_buttons));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; ack = 1'b1; byte_done = 1'b0; byte_rx = 8'h00;
    for (int c = 0; c < 3; c++) tick();
    check_reset_vals("reset");
    rst_n  = 1'b1;
    e_fall = g_cyc + 1;

    set_poll(40'hFF_41_5A_FB_FF, 4, 2);                 run_poll();
    set_poll(40'hFF_41_5A_12_34, 4, NO_ACK);            run_poll();
    set_poll(40'hFF_41_00_7E_EF, 4, 2);                 run_poll();
    set_poll(40'hFF_73_5A_AA_55, 5, -2);                run_poll();
    set_poll(40'hFF_41_5A_0F_F0, 3, ACK_TIMEOUT - SYNC_LAT); run_poll();
    set_poll(40'hFF_41_5A_11_22, 4, 2);
    p_ackd[1] = ACK_TIMEOUT - SYNC_LAT + 1;             run_poll();
    set_poll(40'hFF_41_5A_C3_3C, 4, 2);
    p_ackd[2] = NO_ACK; p_rst_byte = 2;                 run_poll();
    set_poll(40'hFF_41_5A_FE_7F, 4, 3);                 run_poll();

    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 5; k++) begin
        p_rx[k]  = 8'($urandom);
        p_lat[k] = $urandom_range(3, 6);
      end
      if ($urandom_range(0, 4) != 0) p_rx[2] = 8'h5A;
      for (int k = 0; k < 4; k++)
        p_ackd[k] = ($urandom_range(0, 9) == 0) ? NO_ACK : int'($urandom_range(0, 9)) - 2;
      p_rst_byte = -1;
      p_drop_en  = 1'b0;
      run_poll();
    end

    enable = 1'b0;
    idle_no_poll(500, "en_off");
    enable = 1'b1;
    e_fall = g_cyc + 1;
    set_poll(40'hFF_41_5A_DE_AD, 4, 1);
    p_drop_en = 1'b1;                                   run_poll();
    idle_no_poll(300, "en_drop");
    enable = 1'b1;
    e_fall = g_cyc + 1;
    set_poll(40'hFF_41_5A_BE_EF, 6, 4);                 run_poll();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
